// File: rtl/tb_watchdog.sv
// tb_watchdog: run monitor for a simulation top. Tracks one test run from start to a
// sticky verdict (pass, error or timeout) and exposes progress counters.
//
// Optional feature macro: TB_WATCHDOG_KICK_EN
//   defined   - kick_i in ARMED reloads the timeout budget (budget per kick interval)
//   undefined - kick_i is ignored (budget covers the whole run); the port stays present
//
// Parameters
//   CNT_W           width of the internal counters and count outputs
//   TIMEOUT_CYCLES  cycle budget, legal range 1 .. 2^CNT_W-1
//
// Ports
//   clk_i             clock, all state updates on the rising edge
//   rst_i             asynchronous active-high reset
//   start_i           arm a run (IDLE only)
//   kick_i            heartbeat (see macro above)
//   done_i            bench reports success
//   error_i           bench reports failure, error_code_i captured with it
//   error_code_i      failure reason
//   clear_i           leave a terminal state back to IDLE
//   running_o         high while ARMED
//   pass_o            sticky, high in PASS
//   fail_o            sticky, high in ERROR or TIMEOUT
//   timed_out_o       sticky, high in TIMEOUT
//   fail_code_o       captured error code, 8'hFF on timeout, 0 otherwise
//   cycles_elapsed_o  ARMED cycles in the current run, saturating
//   remaining_o       cycles left before timeout
module tb_watchdog #(
  parameter int unsigned      CNT_W          = 32,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = CNT_W'(1000000)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             kick_i,
  input  logic             done_i,
  input  logic             error_i,
  input  logic [7:0]       error_code_i,
  input  logic             clear_i,
  output logic             running_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timed_out_o,
  output logic [7:0]       fail_code_o,
  output logic [CNT_W-1:0] cycles_elapsed_o,
  output logic [CNT_W-1:0] remaining_o
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StPass,
    StError,
    StTimeout
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [7:0]       TimeoutCode = 8'hFF;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [7:0]       fail_code_q, fail_code_d;

  logic             kick_reload;
  logic [CNT_W-1:0] remaining_dec;
  logic [CNT_W-1:0] elapsed_inc;

`ifdef TB_WATCHDOG_KICK_EN
  assign kick_reload = kick_i;
`else
  logic unused_kick;
  assign unused_kick = kick_i;
  assign kick_reload = 1'b0;
`endif

  // Decrement floors at zero so a stray zero can never wrap to a huge budget.
  assign remaining_dec = (remaining_q == '0) ? '0 : remaining_q - CntOne;
  assign elapsed_inc   = (elapsed_q == CntMax) ? CntMax : elapsed_q + CntOne;

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      elapsed_q   <= '0;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      elapsed_q   <= elapsed_d;
      fail_code_q <= fail_code_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    elapsed_d   = elapsed_q;
    fail_code_d = fail_code_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StArmed;
          remaining_d = TIMEOUT_CYCLES;
          elapsed_d   = '0;
          fail_code_d = '0;
        end
      end

      StArmed: begin
        elapsed_d = elapsed_inc;
        // Verdicts outrank the kick, so the final edge of a run always counts down.
        if (error_i) begin
          state_d     = StError;
          remaining_d = remaining_dec;
          fail_code_d = error_code_i;
        end else if (done_i) begin
          state_d     = StPass;
          remaining_d = remaining_dec;
        end else if (kick_reload) begin
          remaining_d = TIMEOUT_CYCLES;
        end else begin
          remaining_d = remaining_dec;
          if (remaining_q <= CntOne) begin
            state_d     = StTimeout;
            fail_code_d = TimeoutCode;
          end
        end
      end

      StPass, StError, StTimeout: begin
        // Counters and fail code stay frozen, even across clear, until the next start.
        if (clear_i) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from registers, so they are glitch-free and registered.
  always_comb begin
    running_o        = (state_q == StArmed);
    pass_o           = (state_q == StPass);
    fail_o           = (state_q == StError) || (state_q == StTimeout);
    timed_out_o      = (state_q == StTimeout);
    fail_code_o      = fail_code_q;
    cycles_elapsed_o = elapsed_q;
    remaining_o      = remaining_q;
  end

endmodule

// File: doc/tb_watchdog.md
# tb_watchdog

Synthesizable run monitor that sits beside the testbench top, on the same `clk`. It tracks one test run from start to a terminal verdict: pass, error, or timeout. The top samples its sticky verdict outputs to decide whether to print success or failure and to end simulation. This replaces the ad-hoc free-running timeout countdown with a checked, reusable block.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: cycle budget per run (or per kick interval); legal range 1 .. 2^CNT_W-1.
- `CNT_W`, default 32: width of the internal counters and the count outputs.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: arm the run; honoured only in IDLE.
- `kick`  in  1: heartbeat from the bench; see Configuration.
- `done`  in  1: bench reports successful completion.
- `error`  in  1: bench reports a failure.
- `error_code`  in  8: failure reason, captured together with `error`.
- `clear`  in  1: return from any terminal state to IDLE.
- `running`  out  1: high in ARMED.
- `pass`  out  1: sticky; high in PASS.
- `fail`  out  1: sticky; high in ERROR or TIMEOUT.
- `timed_out`  out  1: sticky; high in TIMEOUT.
- `fail_code`  out  8: captured `error_code`; 8'hFF on timeout; 0 otherwise.
- `cycles_elapsed`  out  CNT_W: ARMED cycles in the current run; saturates at all-ones.
- `remaining`  out  CNT_W: cycles left before timeout.

## Operation
- States: IDLE, ARMED, PASS, ERROR, TIMEOUT. All outputs are registered.
- **Reset** (any state, any cycle, including mid-run): state goes to IDLE. All outputs are 0, including `remaining`.
- **IDLE, with `start`:**
  - Go to ARMED.
  - Load `remaining` with TIMEOUT_CYCLES.
  - Clear `cycles_elapsed` and `fail_code`.
  - `done`, `error` and `kick` are ignored in IDLE.
- **ARMED, every cycle:**
  - `cycles_elapsed` increments, saturating.
  - `remaining` decrements by 1 unless a reload applies.
- **ARMED priority when events coincide:** `error` > `done` > timeout.
  - `error`: go to ERROR and capture `error_code`.
  - `done`: go to PASS.
  - Timeout: `remaining` == 1 and no reload this cycle. `remaining` goes to 0, state goes to TIMEOUT and `fail_code` is set to 8'hFF.
- **Terminal states** (PASS, ERROR, TIMEOUT):
  - Hold the state and all counters frozen.
  - Ignore `start`, `done`, `error` and `kick`.
  - `clear`: go to IDLE. `pass`/`fail`/`timed_out` drop. Counters and `fail_code` hold until the next `start`.
- `clear` in IDLE or ARMED has no effect.
- `start` in ARMED has no effect; it does not restart the run.

## Timing
- Latency from inputs to outputs:
  - `start` sampled at edge N: `running`=1 and `remaining`=TIMEOUT_CYCLES after edge N.
  - `done`/`error` sampled at edge N: verdict outputs valid after edge N, and `running`=0.
- Timeout cycle count: with no kicks, `timed_out` rises exactly TIMEOUT_CYCLES edges after the edge that sampled `start`. At that point `cycles_elapsed` = TIMEOUT_CYCLES.
- TIMEOUT_CYCLES=1: timeout on the first ARMED edge, unless `done` or `error` is high on that edge.
- Reset assertion is asynchronous. The first state change after release happens at the first rising `clk` edge.

## Configuration
- Macro: `TB_WATCHDOG_KICK_EN`.
- **Defined:** `kick` high in ARMED reloads `remaining` to TIMEOUT_CYCLES instead of decrementing, so the budget is per kick interval. A kick on the would-be-timeout cycle (`remaining`==1) prevents the timeout. `error`/`done` still take priority over `kick`.
- **Undefined:** `kick` is ignored and the budget is the total run length. The port remains present and is unused.

## Test plan
- Reset, then `start` with TIMEOUT_CYCLES=100, then `done` at ARMED cycle 40 -> `pass`=1, `fail`=0, `cycles_elapsed`=40, `remaining`=60.
- `start`, then `error` with `error_code`=8'h3C at cycle 10 -> `fail`=1, `fail_code`=8'h3C, `timed_out`=0. Later `done` pulses leave the state unchanged.
- `start`, no kicks, TIMEOUT_CYCLES=100 -> `timed_out` and `fail` rise at edge 100, `fail_code`=8'hFF, `remaining`=0.
- `done` and `error` high on the same edge that `remaining`==1 -> ERROR wins; `timed_out`=0.
- With `TB_WATCHDOG_KICK_EN`: kick every 90 cycles for 500 cycles -> no timeout. After the last kick, `timed_out` rises 100 edges later. Without the macro, the same stimulus times out at edge 100.
- `rst` asserted mid-ARMED at cycle 37 -> all outputs 0 immediately. After release, `start` behaves as a fresh run. `clear` after PASS returns to IDLE and a new `start` re-arms.
